// File: rtl/bram_arb2.sv
// Round-robin arbiter sharing one block-RAM port between two requesters.
// It limits bursts to BURST_LEN grants under contention and routes each read response back to its issuer.
module bram_arb2 #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    localparam logic [7:0] BURST_MAX = 8'(BURST_LEN);

    logic       owner;
    logic [7:0] cnt;
    logic       rd_pend;
    logic       rd_tag;
    logic       pick;
    logic       gnt_any;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Stage 0: combinational grant and RAM port mux; this is the critical path
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        pick   = (cnt < BURST_MAX) ? owner : ~owner;
        if (!rst) begin
            if (m0_req && m1_req) begin
                m0_gnt = ~pick;
                m1_gnt = pick;
            end else begin
                m0_gnt = m0_req;
                m1_gnt = m1_req;
            end
        end
    end

    assign gnt_any = m0_gnt | m1_gnt;

    always_comb begin
        ram_en   = gnt_any;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (m0_gnt) begin
            ram_we   = m0_we;
            ram_addr = m0_addr;
            ram_din  = m0_wdata;
        end else if (m1_gnt) begin
            ram_we   = m1_we;
            ram_addr = m1_addr;
            ram_din  = m1_wdata;
        end
    end

    // Stage 1: burst bookkeeping and read-response tag, aligned with the RAM's registered read
    always_ff @(posedge clk) begin
        if (rst) begin
            owner   <= 1'b0;
            cnt     <= 8'd0;
            rd_pend <= 1'b0;
            rd_tag  <= 1'b0;
        end else begin
            if (gnt_any) begin
                if (m1_gnt == owner) begin
                    cnt <= sat_inc(cnt);
                end else begin
                    owner <= m1_gnt;
                    cnt   <= 8'd1;
                end
                rd_tag <= m1_gnt;
            end else begin
                cnt <= 8'd0;
            end
            rd_pend <= gnt_any & ~ram_we;
        end
    end

    assign m0_rvalid = rd_pend & ~rd_tag;
    assign m1_rvalid = rd_pend & rd_tag;
    assign m0_rdata  = ram_dout;
    assign m1_rdata  = ram_dout;

endmodule

// File: tb/tb_bram_arb2.sv
// Bench for bram_arb2: directed scenarios followed by randomized traffic.
// A grant-history reference model and a behavioural RAM check every cycle.
module tb_bram_arb2;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din, ram_dout;

    always #5 clk = ~clk;

    bram_arb2 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
        return 32'hA5A5_0000 ^ {{(DW-AW){1'b0}}, a};
    endfunction

    // Behavioural RAM port: registered read, no-change on write
    logic [DW-1:0]      mem [0:(1<<AW)-1];
    logic [(1<<AW)-1:0] mem_ok;
    logic               mem_clr;

    always @(posedge clk) begin
        if (mem_clr) begin
            mem_ok <= '0;
        end else if (ram_en && ram_we) begin
            mem[ram_addr]    <= ram_din;
            mem_ok[ram_addr] <= 1'b1;
        end
        if (ram_en && !ram_we)
            ram_dout <= mem_ok[ram_addr] ? mem[ram_addr] : dflt(ram_addr);
    end

    // Reference model: grant history since reset, memory contents, responses due this cycle
    typedef struct {
        int            tag;
        logic [DW-1:0] data;
    } resp_t;

    int            hist[$];
    resp_t         resp_q[$];
    logic [DW-1:0] ref_mem [int];

    int            checks = 0;
    int            errors = 0;
    int            obs_g;
    int            last_g;
    logic          obs_rv0, obs_rv1;
    logic [DW-1:0] obs_rd0, obs_rd1;

    function automatic int owner_of();
        for (int i = hist.size() - 1; i >= 0; i--)
            if (hist[i] >= 0) return hist[i];
        return 0;
    endfunction

    function automatic int run_len();
        int o;
        int n;
        o = owner_of();
        n = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != o) break;
            n++;
        end
        return (n > 255) ? 255 : n;
    endfunction

    function automatic int exp_gnt();
        if (rst) return -1;
        if (m0_req && m1_req) return (run_len() < BL) ? owner_of() : 1 - owner_of();
        if (m0_req) return 0;
        if (m1_req) return 1;
        return -1;
    endfunction

    task automatic check1(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set0(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        m0_req = r; m0_we = w; m0_addr = a; m0_wdata = d;
    endtask

    task automatic set1(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        m1_req = r; m1_we = w; m1_addr = a; m1_wdata = d;
    endtask

    // One clock cycle: compare outputs at the falling edge, then advance the model at the rising edge
    task automatic cycle();
        int            g;
        logic          ew;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic          rv0, rv1;
        @(negedge clk);
        g   = exp_gnt();
        ew  = (g == 0) ? m0_we    : (g == 1) ? m1_we    : 1'b0;
        ea  = (g == 0) ? m0_addr  : (g == 1) ? m1_addr  : '0;
        ed  = (g == 0) ? m0_wdata : (g == 1) ? m1_wdata : '0;
        rv0 = (resp_q.size() > 0) && (resp_q[0].tag == 0);
        rv1 = (resp_q.size() > 0) && (resp_q[0].tag == 1);
        obs_g   = m1_gnt ? 1 : (m0_gnt ? 0 : -1);
        obs_rv0 = m0_rvalid; obs_rv1 = m1_rvalid;
        obs_rd0 = m0_rdata;  obs_rd1 = m1_rdata;
        check1("m0_gnt", 64'(m0_gnt), 64'(g == 0));
        check1("m1_gnt", 64'(m1_gnt), 64'(g == 1));
        check1("ram_en", 64'(ram_en), 64'(g >= 0));
        check1("ram_we", 64'(ram_we), 64'(ew));
        check1("ram_addr", 64'(ram_addr), 64'(ea));
        check1("ram_din", 64'(ram_din), 64'(ed));
        check1("m0_rvalid", 64'(m0_rvalid), 64'(rv0));
        check1("m1_rvalid", 64'(m1_rvalid), 64'(rv1));
        if (rv0) check1("m0_rdata", 64'(m0_rdata), 64'(resp_q[0].data));
        if (rv1) check1("m1_rdata", 64'(m1_rdata), 64'(resp_q[0].data));
        @(posedge clk);
        resp_q.delete();
        if (rst) begin
            hist.delete();
        end else begin
            hist.push_back(g);
            if (g >= 0) begin
                if (ew) ref_mem[int'(ea)] = ed;
                else resp_q.push_back('{g, ref_mem.exists(int'(ea)) ? ref_mem[int'(ea)] : dflt(ea)});
            end
        end
        last_g = g;
        #1;
    endtask

    task automatic rand_req(input int idx);
        logic          r, w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        r = $urandom_range(3) != 0;
        w = $urandom_range(2) == 0;
        a = ($urandom_range(9) == 0) ? AW'(10'h3FF) : AW'($urandom_range(15));
        d = $urandom;
        if (idx == 0) begin
            if (!(m0_req && last_g != 0 && $urandom_range(7) != 0)) set0(r, w, a, d);
        end else begin
            if (!(m1_req && last_g != 1 && $urandom_range(7) != 0)) set1(r, w, a, d);
        end
    endtask

    initial begin
        rst = 1'b1; mem_clr = 1'b1; last_g = -1;
        set0(0, 0, '0, '0); set1(0, 0, '0, '0);
        repeat (2) @(posedge clk);
        mem_clr = 1'b0;
        #1;
        cycle();
        check1("reset_rvalid0", 64'(obs_rv0), 64'(0));
        check1("reset_gnt", 64'(obs_g), 64'(-1));
        rst = 1'b0;

        // Write then read back through m0
        set0(1, 1, 10'h005, 32'hDEADBEEF); cycle(); check1("s1_wr_gnt", 64'(obs_g), 64'(0));
        set0(1, 0, 10'h005, '0);           cycle(); check1("s1_rd_gnt", 64'(obs_g), 64'(0));
        set0(0, 0, '0, '0);                cycle();
        check1("s1_rvalid0", 64'(obs_rv0), 64'(1));
        check1("s1_rdata0", 64'(obs_rd0), 64'(32'hDEADBEEF));
        check1("s1_rvalid1", 64'(obs_rv1), 64'(0));

        // Continuous contention from reset alternates in bursts of four
        rst = 1'b1; cycle(); rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            set0(1, 0, AW'(i), '0); set1(1, 0, AW'(i + 32), '0);
            cycle();
            check1("s2_seq", 64'(obs_g), 64'((i / 4) % 2));
        end

        // m1 alone for ten cycles keeps the grant, then yields at the first tie
        rst = 1'b1; set0(0, 0, '0, '0); set1(0, 0, '0, '0); cycle(); rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            set1(1, 0, AW'(i), '0); cycle();
            check1("s3_m1_alone", 64'(obs_g), 64'(1));
        end
        set0(1, 0, 10'h040, '0); cycle();
        check1("s3_first_tie", 64'(obs_g), 64'(0));

        // An idle cycle ends the burst, so owner m0 gets a full burst again
        set0(0, 0, '0, '0); set1(0, 0, '0, '0); cycle();
        set0(1, 0, 10'h001, '0); cycle(); cycle();
        set0(0, 0, '0, '0); cycle();
        for (int i = 0; i < 5; i++) begin
            set0(1, 0, AW'(i), '0); set1(1, 0, AW'(i + 8), '0);
            cycle();
            check1("s4_after_idle", 64'(obs_g), 64'((i < 4) ? 0 : 1));
        end

        // Exhausted m0 burst: m1 write wins the tie, m0 then reads the new value
        set0(0, 0, '0, '0); set1(0, 0, '0, '0); cycle();
        for (int i = 0; i < 4; i++) begin
            set0(1, 0, 10'h3FE, '0); cycle();
        end
        set0(1, 0, 10'h3FF, '0); set1(1, 1, 10'h3FF, 32'h0000_1234); cycle();
        check1("s5_wr_gnt", 64'(obs_g), 64'(1));
        set1(0, 0, '0, '0); cycle();
        check1("s5_rd_gnt", 64'(obs_g), 64'(0));
        check1("s5_no_rvalid0", 64'(obs_rv0), 64'(0));
        check1("s5_no_rvalid1", 64'(obs_rv1), 64'(0));
        set0(0, 0, '0, '0); cycle();
        check1("s5_rvalid0", 64'(obs_rv0), 64'(1));
        check1("s5_rdata0", 64'(obs_rd0), 64'(32'h0000_1234));

        // Reset right after a read grant still returns that read
        set0(1, 0, 10'h005, '0); cycle();
        rst = 1'b1; set1(1, 0, 10'h006, '0); cycle();
        check1("s6_rst_rvalid0", 64'(obs_rv0), 64'(1));
        check1("s6_rst_gnt", 64'(obs_g), 64'(-1));
        for (int i = 0; i < 2; i++) begin
            cycle();
            check1("s6_held_gnt", 64'(obs_g), 64'(-1));
            check1("s6_held_rvalid", 64'({obs_rv0, obs_rv1}), 64'(0));
        end
        rst = 1'b0; cycle();
        check1("s6_first_tie", 64'(obs_g), 64'(0));

        // Randomized traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(99) == 0);
            rand_req(0);
            rand_req(1);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
